lsu_mem_responder: RTL and testbench
====================================

LSU_MEM_RESPONDER -- requirements
Module: lsu_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default lsu_types::ADDR_WIDTH, which is the request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default lsu_types::DATA_WIDTH, which is the word width in bits (multiple of 8).
REQ-003 SHALL have parameter MEM_DEPTH, default 256, which is the number of words (power of 2).
REQ-004 SHALL have parameter READ_LATENCY, default 2, which is the read latency in cycles (>=1).
REQ-005 SHALL have parameter WRITE_LATENCY, default 1, which is the write latency in cycles (>=1).
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port mem_read, input, 1 bit: read request, level, held by the requester until mem_ready.
REQ-009 SHALL have port mem_write, input, 1 bit: write request, level, held by the requester until mem_ready.
REQ-010 SHALL have port mem_addr, input, ADDR_WIDTH bits: byte address.
REQ-011 SHALL have port mem_wdata, input, DATA_WIDTH bits: write data.
REQ-012 SHALL have port mem_rdata, output, DATA_WIDTH bits: registered read data.
REQ-013 SHALL have port mem_ready, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port err_oor, output, 1 bit: sticky flag for an out-of-range address.
REQ-015 SHALL have port err_rw, output, 1 bit: sticky flag for mem_read and mem_write both high at acceptance.
REQ-016 SHALL have ports reads_served, writes_served and stall_cycles, outputs, 32 bits each: saturating counters.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY and RESP; mem_ready SHALL be 1 only in RESP.
REQ-018 In IDLE with mem_read|mem_write high in cycle 0, SHALL capture the op, address and wdata.
- Captured op: write wins if both are high.
REQ-019 Captured LAT SHALL be READ_LATENCY for reads and WRITE_LATENCY for writes (plus any extra from REQ-031).
- Transition to RESP if LAT==1, else to BUSY.
REQ-020 SHALL stay in BUSY for LAT-1 cycles, so mem_ready is high exactly in cycle LAT, then return to IDLE.
REQ-021 SHALL accept the next request no earlier than cycle LAT+1 (one IDLE bubble minimum).
REQ-022 Input changes during BUSY/RESP SHALL be ignored; only captured values are used.
REQ-023 Word index SHALL be mem_addr[$clog2(DATA_WIDTH/8) +: $clog2(MEM_DEPTH)]; low byte-offset bits are ignored.
REQ-024 Any nonzero address bit above the index field SHALL:
- set err_oor;
- complete with normal timing;
- return 0 for reads;
- discard writes.
REQ-025 A write SHALL update the array at the clock edge ending RESP.
REQ-026 A read SHALL load mem_rdata at the edge entering RESP.
- mem_rdata is held until the next read's RESP.
- A read issued after a completed write returns the new data.
REQ-027 reads_served/writes_served SHALL increment by 1 in each RESP cycle of the matching op and saturate at 32'hFFFF_FFFF.
REQ-028 stall_cycles SHALL increment in every cycle with (mem_read|mem_write)=1 and mem_ready=0, saturating.

Reset
REQ-029 On rst_n low, the following SHALL be set immediately, regardless of clock:
- state=IDLE, mem_ready=0, mem_rdata=0;
- err_oor=0, err_rw=0;
- all counters 0;
- LFSR=8'hA5.
REQ-030 The array SHALL NOT be reset; reset mid-BUSY SHALL abort the transaction without any write and without a mem_ready pulse.

Configuration
REQ-031 With LSU_MEM_STALL_INJECT_EN defined, SHALL add extra latency from an 8-bit LFSR:
- LFSR is x^8+x^6+x^5+x^4+1, reset value 8'hA5;
- it advances once per accepted request;
- extra cycles = LFSR[1:0] before advance, added to LAT.
- Without the macro: no LFSR logic, latency fixed per REQ-019.

Verification
REQ-032 Write 0xDEADBEEF @0x10 held high -> mem_ready in cycle 1 only; writes_served=1.
REQ-033 Read @0x10 (default parameters) -> mem_ready in cycle 2; mem_rdata=0xDEADBEEF; stall_cycles += 2.
REQ-034 mem_read and mem_write both high with wdata 0x5 @0x20 -> treated as write; err_rw=1; a later read @0x20 returns 0x5.
REQ-035 Read at an address above MEM_DEPTH*bytes -> mem_rdata=0, err_oor=1, normal latency.
REQ-036 rst_n low in cycle 1 of a READ_LATENCY=3 read -> no mem_ready; all outputs 0; the next read is served normally.
REQ-037 With LSU_MEM_STALL_INJECT_EN defined, the first read after reset SHALL complete in cycle 2+1=3 (LFSR 8'hA5, [1:0]=2'b01).

Source files
------------

// File: rtl/lsu_types.sv
// rtl/lsu_types.sv - shared LSU width defaults
package lsu_types;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/lsu_mem_responder.sv
// rtl/lsu_mem_responder.sv - fixed-latency word memory responder for the LSU
// Optional LFSR stall injection with `define LSU_MEM_STALL_INJECT_EN
module lsu_mem_responder #(
  parameter int ADDR_WIDTH    = lsu_types::ADDR_WIDTH,
  parameter int DATA_WIDTH    = lsu_types::DATA_WIDTH,
  parameter int MEM_DEPTH     = 256,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  err_oor,
  output logic                  err_rw,
  output logic [31:0]           reads_served,
  output logic [31:0]           writes_served,
  output logic [31:0]           stall_cycles
);
  localparam int OFF_W = (DATA_WIDTH / 8 > 1) ? $clog2(DATA_WIDTH / 8) : 0;
  localparam int IDX_W = $clog2(MEM_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [1:0]            state, state_d;
  logic                  op_wr;
  logic                  oor_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [7:0]            cnt;

  logic                  req;
  logic                  accept;
  logic                  idx_oor;
  logic [IDX_W-1:0]      idx_in;
  logic [7:0]            lat;
  logic                  load_rd;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_oor;

  assign req       = mem_read | mem_write;
  assign accept    = (state == S_IDLE) && req;
  assign idx_in    = mem_addr[OFF_W +: IDX_W];
  assign idx_oor   = (mem_addr >> (OFF_W + IDX_W)) != '0;
  assign mem_ready = (state == S_RESP);

`ifdef LSU_MEM_STALL_INJECT_EN
  logic [7:0] lfsr;

  // Extra latency uses the pre-advance LFSR value; it steps once per accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr <= 8'hA5;
    else if (accept)
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign lat = (mem_write ? 8'(WRITE_LATENCY) : 8'(READ_LATENCY)) + {6'd0, lfsr[1:0]};
`else
  assign lat = mem_write ? 8'(WRITE_LATENCY) : 8'(READ_LATENCY);
`endif

  // A single-cycle read bypasses BUSY, so its array index comes straight from the inputs.
  always_comb begin
    state_d = state;
    load_rd = 1'b0;
    rd_idx  = idx_q;
    rd_oor  = oor_q;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_d = (lat == 8'd1) ? S_RESP : S_BUSY;
          if (lat == 8'd1 && !mem_write) begin
            load_rd = 1'b1;
            rd_idx  = idx_in;
            rd_oor  = idx_oor;
          end
        end
      end
      S_BUSY: begin
        if (cnt == 8'd0) begin
          state_d = S_RESP;
          load_rd = !op_wr;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      op_wr         <= 1'b0;
      oor_q         <= 1'b0;
      idx_q         <= '0;
      wdata_q       <= '0;
      cnt           <= '0;
      mem_rdata     <= '0;
      err_oor       <= 1'b0;
      err_rw        <= 1'b0;
      reads_served  <= '0;
      writes_served <= '0;
      stall_cycles  <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        op_wr   <= mem_write;
        oor_q   <= idx_oor;
        idx_q   <= idx_in;
        wdata_q <= mem_wdata;
        cnt     <= (lat >= 8'd2) ? lat - 8'd2 : 8'd0;
        err_oor <= err_oor | idx_oor;
        err_rw  <= err_rw | (mem_read & mem_write);
      end else if (state == S_BUSY && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (load_rd)
        mem_rdata <= rd_oor ? '0 : mem[rd_idx];
      if (state == S_RESP && !op_wr && reads_served != 32'hFFFF_FFFF)
        reads_served <= reads_served + 32'd1;
      if (state == S_RESP && op_wr && writes_served != 32'hFFFF_FFFF)
        writes_served <= writes_served + 32'd1;
      if (req && !mem_ready && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

  // Array has no reset; async reset forces state out of RESP, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (state == S_RESP && op_wr && !oor_q)
      mem[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_lsu_mem_responder.sv
// tb/tb_lsu_mem_responder.sv - randomized self-checking bench for lsu_mem_responder
module tb_lsu_mem_responder;
  localparam int RL    = 2;
  localparam int WL    = 1;
  localparam int BYTES = 256 * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        err_oor;
  logic        err_rw;
  logic [31:0] reads_served;
  logic [31:0] writes_served;
  logic [31:0] stall_cycles;

  int          n_cmp = 0;
  int          n_err = 0;

  int          exp_reads;
  int          exp_writes;
  int          exp_stall;
  bit          exp_oor;
  bit          exp_rw;
  logic [31:0] exp_rdata;
  logic [7:0]  lfsr_m;
  logic [31:0] model [int];
  int          written[$];

  always #5 clk = ~clk;

  lsu_mem_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .err_oor      (err_oor),
    .err_rw       (err_rw),
    .reads_served (reads_served),
    .writes_served(writes_served),
    .stall_cycles (stall_cycles)
  );

  task automatic model_reset();
    exp_reads  = 0;
    exp_writes = 0;
    exp_stall  = 0;
    exp_oor    = 1'b0;
    exp_rw     = 1'b0;
    exp_rdata  = '0;
    lfsr_m     = 8'hA5;
  endtask

  // One complete request/response; inputs are scrambled after acceptance to prove they are ignored.
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input string tag);
    int lat;
    int cyc;
    bit oor;
    int idx;
    oor = (addr >= BYTES);
    idx = int'((addr % BYTES) / 4);
    lat = wr ? WL : RL;
`ifdef LSU_MEM_STALL_INJECT_EN
    lat += int'(lfsr_m % 8'd4);
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`endif
    if (!wr) exp_rdata = oor ? 32'd0 : model[idx];

    @(posedge clk); #1;
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = wdata;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (mem_ready) break;
      cyc++;
      if (cyc > 30) break;
      @(posedge clk); #1;
      mem_addr  = $urandom;
      mem_wdata = $urandom;
    end
    n_cmp++;
    if (cyc != lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", tag, cyc, lat);
    end
    if (!wr) begin
      n_cmp++;
      if (mem_rdata !== exp_rdata) begin
        n_err++;
        $display("FAIL %s rdata: got %h want %h", tag, mem_rdata, exp_rdata);
      end
    end

    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (wr && !oor) model[idx] = wdata;
    if (wr) exp_writes++; else exp_reads++;
    exp_stall += lat;
    exp_oor |= oor;
    exp_rw  |= rd & wr;

    @(negedge clk);
    n_cmp += 7;
    if (mem_ready !== 1'b0) begin
      n_err++; $display("FAIL %s ready_one_cycle: got %b want 0", tag, mem_ready);
    end
    if (reads_served !== 32'(exp_reads)) begin
      n_err++; $display("FAIL %s reads_served: got %0d want %0d", tag, reads_served, exp_reads);
    end
    if (writes_served !== 32'(exp_writes)) begin
      n_err++; $display("FAIL %s writes_served: got %0d want %0d", tag, writes_served, exp_writes);
    end
    if (stall_cycles !== 32'(exp_stall)) begin
      n_err++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, stall_cycles, exp_stall);
    end
    if (err_oor !== exp_oor) begin
      n_err++; $display("FAIL %s err_oor: got %b want %b", tag, err_oor, exp_oor);
    end
    if (err_rw !== exp_rw) begin
      n_err++; $display("FAIL %s err_rw: got %b want %b", tag, err_rw, exp_rw);
    end
    if (mem_rdata !== exp_rdata) begin
      n_err++; $display("FAIL %s rdata_hold: got %h want %h", tag, mem_rdata, exp_rdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp += 7;
    if (mem_ready !== 1'b0) begin n_err++; $display("FAIL reset mem_ready: got %b want 0", mem_ready); end
    if (mem_rdata !== 32'd0) begin n_err++; $display("FAIL reset mem_rdata: got %h want 0", mem_rdata); end
    if (err_oor !== 1'b0) begin n_err++; $display("FAIL reset err_oor: got %b want 0", err_oor); end
    if (err_rw !== 1'b0) begin n_err++; $display("FAIL reset err_rw: got %b want 0", err_rw); end
    if (reads_served !== 32'd0) begin n_err++; $display("FAIL reset reads: got %0d want 0", reads_served); end
    if (writes_served !== 32'd0) begin n_err++; $display("FAIL reset writes: got %0d want 0", writes_served); end
    if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL reset stall: got %0d want 0", stall_cycles); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_directed();
    do_op(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, "wr_0x10");
    do_op(1'b1, 1'b0, 32'h10, 32'h0, "rd_0x10");
    do_op(1'b1, 1'b1, 32'h20, 32'h5, "both_0x20");
    do_op(1'b1, 1'b0, 32'h23, 32'h0, "rd_0x20_offset");
    do_op(1'b1, 1'b0, 32'h1000, 32'h0, "rd_oor");
    do_op(1'b0, 1'b1, 32'h2010, 32'h1234_5678, "wr_oor_alias");
    do_op(1'b1, 1'b0, 32'h10, 32'h0, "rd_0x10_after_oor_wr");
    do_op(1'b0, 1'b1, 32'h3FC, 32'hCAFE_F00D, "wr_top_word");
    do_op(1'b1, 1'b0, 32'h3FC, 32'h0, "rd_top_word");
    written.push_back(4);
    written.push_back(8);
    written.push_back(255);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int kind;
      int idx;
      kind = int'($urandom_range(0, 9));
      if (kind < 4) begin
        idx = int'($urandom_range(0, 255));
        do_op($urandom_range(0, 1) == 1, 1'b1, 32'(idx * 4) + $urandom_range(0, 3), $urandom, "rand_wr");
        written.push_back(idx);
      end else if (kind < 9) begin
        idx = written[$urandom_range(0, written.size() - 1)];
        do_op(1'b1, 1'b0, 32'(idx * 4) + $urandom_range(0, 3), 32'h0, "rand_rd");
      end else begin
        do_op(1'b1, 1'b0, $urandom | 32'h400, 32'h0, "rand_rd_oor");
      end
    end
  endtask

  // Assert reset one cycle into a transaction and confirm it never completes.
  task automatic abort_op(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input string tag);
    @(posedge clk); #1;
    mem_read  = !wr;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = wdata;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 4;
    if (mem_ready !== 1'b0) begin n_err++; $display("FAIL %s ready: got %b want 0", tag, mem_ready); end
    if (mem_rdata !== 32'd0) begin n_err++; $display("FAIL %s rdata: got %h want 0", tag, mem_rdata); end
    if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL %s stall: got %0d want 0", tag, stall_cycles); end
    if ((err_oor | err_rw) !== 1'b0 || (reads_served | writes_served) !== 32'd0) begin
      n_err++; $display("FAIL %s flags_counters: got %b/%b/%0d/%0d want 0", tag, err_oor, err_rw,
                        reads_served, writes_served);
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (mem_ready !== 1'b0) begin n_err++; $display("FAIL %s ready_in_reset: got %b want 0", tag, mem_ready); end
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset_abort();
    do_op(1'b0, 1'b1, 32'h40, 32'h1111_2222, "pre_wr_0x40");
    abort_op(1'b1, 32'h10, 32'h0, "abort_read");
    do_op(1'b1, 1'b0, 32'h10, 32'h0, "rd_after_abort");
    abort_op(1'b0, 32'h40, 32'h9999_AAAA, "abort_write");
    do_op(1'b1, 1'b0, 32'h40, 32'h0, "rd_0x40_unchanged");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_directed();
    test_random();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
